tri_bus_driver: RTL

Upstream driver for a shared 32-bit tristate word bus whose consumer splits each word into packed fields by concatenation. Buffers incoming words in a small FIFO, requests the bus, drives buffered words one per cycle while granted, then releases the bus to high-impedance. A mandatory turnaround gap follows every release so a second driver on the same net never overlaps.

---
 rtl/tri_bus_if.sv | 25 ++
 rtl/tri_bus_driver.sv | 96 +++++++++
 2 files changed

// File: rtl/tri_bus_if.sv
// Producer-side handshake and shared tristate word bus for tri_bus_driver.
// master = the driver, slave = the environment (source, arbiter, bus observer).
interface tri_bus_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  logic                     in_valid;
  logic [WIDTH-1:0]         in_data;
  logic                     in_ready;
  logic                     bus_grant;
  logic                     bus_req;
  logic                     bus_oe;
  logic [WIDTH-1:0]         bus_data;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    input  in_valid, in_data, bus_grant,
    output in_ready, bus_req, bus_oe, bus_data, count
  );

  modport slave (
    output in_valid, in_data, bus_grant,
    input  in_ready, bus_req, bus_oe, bus_data, count
  );
endinterface

// File: rtl/tri_bus_driver.sv
// Buffers words in a small FIFO and drives them onto a shared tristate bus
// while granted, with a guaranteed high-Z turnaround after every release.
module tri_bus_driver #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int TURN  = 1
) (
  input  logic      clk,
  input  logic      rst,
  tri_bus_if.master b
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TURN > 1) ? $clog2(TURN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRIVE, S_TURN} state_t;

  state_t           state, nxt;
  logic             req_q, oe_q, req_d, oe_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic [TW-1:0]    tcnt;
  logic [WIDTH-1:0] bus_reg;
  logic             push, load;

  assign b.in_ready = (cnt != CW'(DEPTH));
  assign b.count    = cnt;
  assign b.bus_req  = req_q;
  assign b.bus_oe   = oe_q;
  assign b.bus_data = oe_q ? bus_reg : 'z;

  assign push = b.in_valid && b.in_ready;
  // Head leaves the FIFO exactly when it is captured into the bus register.
  assign load = b.bus_grant && (cnt != '0) && (state == S_REQ || state == S_DRIVE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      req_q <= 1'b0;
      oe_q  <= 1'b0;
    end else begin
      state <= nxt;
      req_q <= req_d;
      oe_q  <= oe_d;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (cnt != '0) nxt = S_REQ;
      S_REQ:   if (load) nxt = S_DRIVE;
      S_DRIVE: if (!load) nxt = S_TURN;
      S_TURN:  if (tcnt == TW'(TURN - 1)) nxt = (cnt != '0) ? S_REQ : S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_d = 1'b0;
    oe_d  = 1'b0;
    case (nxt)
      S_REQ:   req_d = 1'b1;
      S_DRIVE: begin req_d = 1'b1; oe_d = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      tcnt    <= '0;
      bus_reg <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (load) begin
        rd_ptr  <= rd_ptr + AW'(1);
        bus_reg <= mem[rd_ptr];
      end
      case ({push, load})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
      tcnt <= (state == S_TURN) ? tcnt + TW'(1) : '0;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= b.in_data;
  end
endmodule
